// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - MIPS16 execute stage: single-cycle ALU plus iterative shift-add MUL
module exec_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic [ADDR_W-1:0] dest,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_zero,
  output logic              wb_ovf
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;
  localparam int MSB = DATA_W - 1;

  logic [0:0]        state;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] mul_dest;

  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [DATA_W-1:0] mul_step;
  logic              accept;

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign sum      = src_a + src_b;
  assign diff     = src_a - src_b;
  // The last step folds the final partial product straight into wb_data.
  assign mul_step = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_res = sum;
        alu_ovf = (src_a[MSB] == src_b[MSB]) && (sum[MSB] != src_a[MSB]);
      end
      3'b001: begin
        alu_res = diff;
        alu_ovf = (src_a[MSB] != src_b[MSB]) && (diff[MSB] != src_a[MSB]);
      end
      3'b010:  alu_res = src_a & src_b;
      3'b011:  alu_res = src_a | src_b;
      3'b100:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b101:  alu_res = src_a << src_b[3:0];
      3'b110:  alu_res = src_a >> src_b[3:0];
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      mul_dest <= '0;
      wb_en    <= 1'b0;
      wb_dest  <= '0;
      wb_data  <= '0;
      wb_zero  <= 1'b0;
      wb_ovf   <= 1'b0;
    end else begin
      wb_en   <= 1'b0;
      wb_zero <= 1'b0;
      wb_ovf  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (alu_op == 3'b111) begin
              state    <= S_MUL;
              mcand    <= src_a;
              mplier   <= src_b;
              mul_dest <= dest;
              acc      <= '0;
              cnt      <= '0;
            end else begin
              wb_en   <= 1'b1;
              wb_dest <= dest;
              wb_data <= alu_res;
              wb_zero <= (alu_res == '0);
              wb_ovf  <= alu_ovf;
            end
          end
        end
        S_MUL: begin
          if (cnt == CNT_LAST) begin
            state   <= S_IDLE;
            wb_en   <= 1'b1;
            wb_dest <= mul_dest;
            wb_data <= mul_step;
            wb_zero <= (mul_step == '0);
          end else begin
            acc    <= mul_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - scoreboard bench for exec_unit with directed vectors
module tb_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_op;
  logic [15:0] src_a;
  logic [15:0] src_b;
  logic [2:0]  dest;
  logic        wb_en;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic        wb_zero;
  logic        wb_ovf;

  typedef struct packed {
    logic [2:0]  d;
    logic [15:0] data;
    logic        z;
    logic        o;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  exec_unit #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .src_a(src_a), .src_b(src_b), .dest(dest),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .wb_zero(wb_zero), .wb_ovf(wb_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
  endtask

  // Monitor: every write-back must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && wb_en) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_wb actual dest=%0d data=%h required=no write-back at %0t",
                 wb_dest, wb_data, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("wb_triple", {11'd0, wb_dest, wb_data, wb_zero, wb_ovf}, {11'd0, e});
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d, input logic [15:0] res, input logic ovf);
    in_valid = 1'b1;
    alu_op   = op;
    src_a    = a;
    src_b    = b;
    dest     = d;
    if (op != 3'b111) q.push_back('{d, res, (res == 16'h0), ovf});
    @(posedge clk);
    #1;
  endtask

  // Returns just after E16, or after releasing reset when abort_at is non-zero.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [2:0] d,
                         input logic [15:0] prod, input int abort_at);
    issue(3'b111, a, b, d, 16'h0, 1'b0);
    if (abort_at == 0) q.push_back('{d, prod, (prod == 16'h0), 1'b0});
    for (int k = 1; k <= 16; k++) begin
      check("mul_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("mul_wb_quiet", {31'd0, wb_en}, 32'd0);
      in_valid = 1'b1;
      alu_op   = 3'b000;
      src_a    = 16'($urandom);
      src_b    = 16'($urandom);
      dest     = 3'($urandom);
      if (k == abort_at) begin
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_wb_en", {31'd0, wb_en}, 32'd0);
        check("abort_wb_data", {16'd0, wb_data}, 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
    end
    check("mul_done_ready", {31'd0, in_ready}, 32'd1);
    check("mul_done_wb_en", {31'd0, wb_en}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    alu_op   = 3'b000;
    src_a    = 16'h1234;
    src_b    = 16'h1111;
    dest     = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_en", {31'd0, wb_en}, 32'd0);
    check("rst_wb_data", {16'd0, wb_data}, 32'd0);
    check("rst_wb_zero", {31'd0, wb_zero}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_wb_en", {31'd0, wb_en}, 32'd0);

    issue(3'b000, 16'h7FFF, 16'h0001, 3'd2, 16'h8000, 1'b1);
    check("b2b_wb_en_1", {31'd0, wb_en}, 32'd1);
    issue(3'b001, 16'h0005, 16'h0005, 3'd3, 16'h0000, 1'b0);
    check("b2b_wb_en_2", {31'd0, wb_en}, 32'd1);
    issue(3'b100, 16'hFFFF, 16'h0001, 3'd4, 16'h0001, 1'b0);
    check("b2b_wb_en_3", {31'd0, wb_en}, 32'd1);
    issue(3'b101, 16'h0003, 16'h0012, 3'd1, 16'h000C, 1'b0);
    issue(3'b110, 16'h8000, 16'h000F, 3'd0, 16'h0001, 1'b0);
    issue(3'b010, 16'hF0F0, 16'h3C3C, 3'd7, 16'h3030, 1'b0);
    issue(3'b011, 16'h00F0, 16'h0F00, 3'd6, 16'h0FF0, 1'b0);
    issue(3'b001, 16'h8000, 16'h0001, 3'd1, 16'h7FFF, 1'b1);
    issue(3'b100, 16'h0001, 16'hFFFF, 3'd2, 16'h0000, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle_wb_en", {31'd0, wb_en}, 32'd0);

    // Inputs churn during the MUL; the held OR request must land at E17.
    run_mul(16'h0123, 16'h0010, 3'd5, 16'h1230, 0);
    in_valid = 1'b1;
    alu_op   = 3'b011;
    src_a    = 16'h0A00;
    src_b    = 16'h000B;
    dest     = 3'd6;
    q.push_back('{3'd6, 16'h0A0B, 1'b0, 1'b0});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("held_req_wb_en", {31'd0, wb_en}, 32'd1);

    run_mul(16'hFFFF, 16'hFFFF, 3'd6, 16'h0001, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    run_mul(16'h0101, 16'h0202, 3'd3, 16'h0000, 8);
    repeat (20) @(posedge clk);
    #1;
    check("post_abort_ready", {31'd0, in_ready}, 32'd1);

    issue(3'b000, 16'h0002, 16'hFFFE, 3'd0, 16'h0000, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
